// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: denomination count, coin values,
// default datapath width and FSM state encoding.
package change_dispenser_pkg;

    localparam int kNumCoins = 3;
    localparam int kAmtW     = 32;

    localparam logic [kAmtW-1:0] kCoin0Value = 32'd100;
    localparam logic [kAmtW-1:0] kCoin1Value = 32'd500;
    localparam logic [kAmtW-1:0] kCoin2Value = 32'd1000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    // Unknown denominations report value 0 so the picker never selects them.
    function automatic logic [kAmtW-1:0] coin_value(input int idx);
        logic [kAmtW-1:0] v;
        case (idx)
            32'sd0:  v = kCoin0Value;
            32'sd1:  v = kCoin1Value;
            32'sd2:  v = kCoin2Value;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: highest denomination that fits the remainder
// and still has stock.
module coin_select
    import change_dispenser_pkg::*;
#(
    parameter int NUM_COINS = kNumCoins,
    parameter int AMT_W     = kAmtW,
    parameter int STOCK_W   = 8
) (
    input  logic [AMT_W-1:0]                    remainder,
    input  logic [NUM_COINS-1:0][STOCK_W-1:0]   stock,
    output logic                                found,
    output logic [NUM_COINS-1:0]                coin_onehot,
    output logic [AMT_W-1:0]                    coin_amount
);

    // Scan upward so the last eligible (highest) index wins.
    always_comb begin
        found       = 1'b0;
        coin_onehot = '0;
        coin_amount = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if ((AMT_W'(coin_value(i)) != '0) &&
                (AMT_W'(coin_value(i)) <= remainder) &&
                (stock[i] != '0)) begin
                found          = 1'b1;
                coin_onehot    = '0;
                coin_onehot[i] = 1'b1;
                coin_amount    = AMT_W'(coin_value(i));
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: greedy coin return with per-denomination stock and refill.
// Define DISPENSE_GAP_EN to insert one idle settle cycle after every coin.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int NUM_COINS  = kNumCoins,
    parameter int AMT_W      = kAmtW,
    parameter int STOCK_W    = 8,
    parameter int INIT_STOCK = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_return_req,
    input  logic [AMT_W-1:0]      i_return_amount,
    input  logic [NUM_COINS-1:0]  i_refill,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [AMT_W-1:0]      o_shortfall,
    output logic [NUM_COINS-1:0]  o_stock_empty
);

`ifdef DISPENSE_GAP_EN
    localparam logic kGapEn = 1'b1;
`else
    localparam logic kGapEn = 1'b0;
`endif

    localparam logic [STOCK_W-1:0] kInitStock = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] kStockOne  = {{(STOCK_W-1){1'b0}}, 1'b1};

    state_e                             state_r, state_s;
    logic [AMT_W-1:0]                   remainder_r, remainder_s;
    logic [NUM_COINS-1:0][STOCK_W-1:0]  stock_r, stock_s;
    logic                               gap_r, gap_s;
    logic [NUM_COINS-1:0]               coin_s, empty_s;
    logic                               busy_s, done_s;
    logic [AMT_W-1:0]                   shortfall_s;
    logic [AMT_W-1:0]                   sel_remainder_s, sel_amount_s;
    logic                               sel_found_s;
    logic [NUM_COINS-1:0]               sel_onehot_s;

    // In IDLE the first coin is chosen straight from the request amount.
    always_comb begin
        sel_remainder_s = remainder_r;
        if (state_r == ST_IDLE) begin
            sel_remainder_s = i_return_amount;
        end else begin
            sel_remainder_s = remainder_r;
        end
    end

    coin_select #(
        .NUM_COINS (NUM_COINS),
        .AMT_W     (AMT_W),
        .STOCK_W   (STOCK_W)
    ) u_coin_select (
        .remainder   (sel_remainder_s),
        .stock       (stock_r),
        .found       (sel_found_s),
        .coin_onehot (sel_onehot_s),
        .coin_amount (sel_amount_s)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_s     = state_r;
        remainder_s = remainder_r;
        gap_s       = 1'b0;
        coin_s      = '0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        shortfall_s = o_shortfall;
        case (state_r)
            ST_IDLE: begin
                if (i_return_req) begin
                    shortfall_s = '0;
                    if (sel_found_s) begin
                        coin_s      = sel_onehot_s;
                        remainder_s = i_return_amount - sel_amount_s;
                        busy_s      = 1'b1;
                        gap_s       = kGapEn;
                        state_s     = ST_DISPENSE;
                    end else begin
                        remainder_s = i_return_amount;
                        done_s      = 1'b1;
                        shortfall_s = i_return_amount;
                        state_s     = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                if (!sel_found_s) begin
                    done_s      = 1'b1;
                    shortfall_s = remainder_r;
                    state_s     = ST_DONE;
                end else if (gap_r) begin
                    busy_s = 1'b1;
                end else begin
                    coin_s      = sel_onehot_s;
                    remainder_s = remainder_r - sel_amount_s;
                    busy_s      = 1'b1;
                    gap_s       = kGapEn;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Stock update: refill and dispense of one denomination cancel; refill saturates.
    always_comb begin
        stock_s = stock_r;
        empty_s = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (i_refill[i] && !coin_s[i]) begin
                if (stock_r[i] != '1) begin
                    stock_s[i] = stock_r[i] + kStockOne;
                end else begin
                    stock_s[i] = stock_r[i];
                end
            end else if (!i_refill[i] && coin_s[i]) begin
                stock_s[i] = stock_r[i] - kStockOne;
            end else begin
                stock_s[i] = stock_r[i];
            end
            empty_s[i] = (stock_s[i] == '0);
        end
    end

    // State, stock and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            remainder_r   <= '0;
            stock_r       <= {NUM_COINS{kInitStock}};
            gap_r         <= 1'b0;
            o_return_coin <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_shortfall   <= '0;
            o_stock_empty <= {NUM_COINS{(kInitStock == '0)}};
        end else begin
            state_r       <= state_s;
            remainder_r   <= remainder_s;
            stock_r       <= stock_s;
            gap_r         <= gap_s;
            o_return_coin <= coin_s;
            o_busy        <= busy_s;
            o_done        <= done_s;
            o_shortfall   <= shortfall_s;
            o_stock_empty <= empty_s;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of returns with a coin
// scoreboard, plus hand sequences for refill, ignored requests and reset.
module tb_change_dispenser;

`ifdef DISPENSE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        return_req;
    logic [31:0] return_amount;
    logic [2:0]  refill;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_shortfall;
    logic [2:0]  o_stock_empty;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic [31:0] amount;
        int          k;
        logic [35:0] coins;
        logic [31:0] shortfall;
    } vec_t;

    vec_t tbl[10];

    change_dispenser dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_return_req    (return_req),
        .i_return_amount (return_amount),
        .i_refill        (refill),
        .o_return_coin   (o_return_coin),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_shortfall     (o_shortfall),
        .o_stock_empty   (o_stock_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input int k, input logic [35:0] c,
                                input logic [31:0] sf);
        vec_t v;
        v.amount = a; v.k = k; v.coins = c; v.shortfall = sf;
        return v;
    endfunction

    task automatic push_coins(input logic [35:0] coins, input int k);
        for (int j = 0; j < k; j++) exp_q.push_back(coins[3*j +: 3]);
    endtask

    // Issue one return and follow it to o_done, popping coins off the scoreboard.
    task automatic run_return(input string name, input logic [31:0] amt, input int k,
                              input logic [35:0] coins, input logic [31:0] exp_sf);
        int cyc;
        bit got_done;
        int exp_done;
        push_coins(coins, k);
        exp_done = GAP ? ((k == 0) ? 1 : 2 * k) : k + 1;
        return_req = 1'b1; return_amount = amt;
        step();
        return_req = 1'b0;
        cyc = 1; got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            if (o_return_coin != 3'b000) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s_extra_coin: got %0h expected none", name, o_return_coin);
                end else begin
                    check({name, "_coin"}, o_return_coin, exp_q.pop_front());
                end
                check({name, "_busy"}, o_busy, 1'b1);
            end
            if (o_done) begin
                got_done = 1'b1;
                check({name, "_done_cycle"}, cyc, exp_done);
                check({name, "_shortfall"}, o_shortfall, exp_sf);
                check({name, "_busy_at_done"}, o_busy, 1'b0);
            end else begin
                step();
                cyc++;
            end
        end
        if (!got_done) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no done expected done by cycle %0d", name, exp_done);
        end
        check({name, "_coins_left"}, exp_q.size(), 0);
        exp_q.delete();
        step();
        check({name, "_done_pulse"}, o_done, 1'b0);
    endtask

    initial begin
        // Table starts from full stock 10/10/10; coins listed first-out in the low octal digit.
        tbl[0] = mk(32'd1600, 3, 36'o124, 32'd0);
        tbl[1] = mk(32'd0,    0, 36'o0,   32'd0);
        tbl[2] = mk(32'd150,  1, 36'o1,   32'd50);
        tbl[3] = mk(32'd2700, 5, 36'o11244, 32'd0);
        tbl[4] = mk(32'd7000, 7, 36'o4444444, 32'd0);
        tbl[5] = mk(32'd1000, 2, 36'o22,  32'd0);
        tbl[6] = mk(32'd400,  4, 36'o1111, 32'd0);
        tbl[7] = mk(32'd200,  2, 36'o11,  32'd0);
        tbl[8] = mk(32'd150,  0, 36'o0,   32'd150);
        tbl[9] = mk(32'd1200, 2, 36'o22,  32'd200);

        reset_n = 1'b0; return_req = 1'b0; return_amount = 32'd0; refill = 3'b000;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("reset_coin", o_return_coin, 3'b000);
        check("reset_busy", o_busy, 1'b0);
        check("reset_done", o_done, 1'b0);
        check("reset_shortfall", o_shortfall, 32'd0);
        check("reset_empty", o_stock_empty, 3'b000);

        for (int i = 0; i < 10; i++) begin
            run_return($sformatf("vec%0d", i), tbl[i].amount, tbl[i].k, tbl[i].coins,
                       tbl[i].shortfall);
            if (i == 4) check("coin2_empty", o_stock_empty, 3'b100);
        end
        check("drained_empty", o_stock_empty, 3'b101);

        // Refill coinciding with the 1000 dispense, plus an ignored second request.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("reset2_empty", o_stock_empty, 3'b000);
        return_req = 1'b1; return_amount = 32'd1600; refill = 3'b100;
        step();
        return_amount = 32'd500; refill = 3'b000;
        check("seqb_coin2", o_return_coin, 3'b100);
        check("seqb_busy", o_busy, 1'b1);
        step();
        return_req = 1'b0;
        if (GAP) step();
        check("seqb_coin1", o_return_coin, 3'b010);
        step();
        if (GAP) step();
        check("seqb_coin0", o_return_coin, 3'b001);
        step();
        check("seqb_done", o_done, 1'b1);
        check("seqb_shortfall", o_shortfall, 32'd0);
        step();
        check("seqb_done_pulse", o_done, 1'b0);
        check("seqb_ignored_req", o_busy, 1'b0);
        // Coin2 stock still 10, so 11000 takes ten 1000s and two 500s.
        run_return("refill_kept", 32'd11000, 12, 36'o224444444444, 32'd0);
        check("refill_kept_empty", o_stock_empty, 3'b100);

        // Reset in the middle of a return abandons it and restocks.
        return_req = 1'b1; return_amount = 32'd600;
        step();
        return_req = 1'b0;
        check("midrst_coin", o_return_coin, 3'b010);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst_coin_clr", o_return_coin, 3'b000);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_done", o_done, 1'b0);
        check("midrst_empty", o_stock_empty, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_quiet", {o_done, o_return_coin}, 4'b0000);
        end
        run_return("restocked", 32'd10000, 10, 36'o4444444444, 32'd0);
        check("restocked_empty", o_stock_empty, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
